div_arbiter: RTL and testbench

- Shares one multi-cycle iterative signed divider among NUM_REQ thread lanes of a core.
- Each lane's ALU path hands DIV operations (rs / rt) to this block instead of dividing combinationally.
- Round-robin request/grant on the input side; one-cycle result pulse, tagged to the winning lane, on the output side.
- Sits beside the per-lane ALUs and is driven during the EXECUTE phase by the lane sequencer.

---
 rtl/div_arb_pkg.sv | 35 +++
 rtl/div_iter.sv | 72 +++++++
 rtl/div_arbiter.sv | 169 ++++++++++++++++
 tb/tb_div_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// rtl/div_arb_pkg.sv - shared types and constants for the lane divider arbiter
package div_arb_pkg;

    // Upper bound on the divider width; width-dependent constants are built
    // at this size and sliced down by the user.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Quotient reported for a zero divisor: all ones (-1) in the low width bits.
    function automatic logic [MAX_WIDTH-1:0] div_zero_quot(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Most negative two's complement value of the given width.
    function automatic logic [MAX_WIDTH-1:0] most_neg(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        v[width-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - unsigned restoring divider core, one quotient bit per cycle
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   start              load operands and begin WIDTH iterations
//   dividend, divisor  unsigned operands, sampled on start
//   done               high during the final iteration cycle
//   quotient,remainder valid the cycle after done
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;   // holds remaining dividend bits, fills with quotient bits
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             running_q;

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    always_comb begin
        partial = {rem_q, quo_q[WIDTH-1]};
        diff    = partial - {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            rem_q     <= '0;
            quo_q     <= dividend;
            dvs_q     <= divisor;
            cnt_q     <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            // Top bit of diff set means a borrow: keep the partial remainder.
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= partial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                running_q <= 1'b0;
            end
        end
    end

    assign done      = running_q && (cnt_q == LAST);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin shared signed divider for NUM_REQ lanes
//
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   req_valid       per-lane request
//   req_ready       one-hot grant (combinational, IDLE only)
//   req_rs, req_rt  packed dividends/divisors, lane i at [i*WIDTH +: WIDTH]
//   resp_valid      one-hot one-cycle result strobe for the granted lane
//   resp_quot       signed quotient, truncated toward zero
//   resp_rem        signed remainder, sign follows dividend
//   busy            high whenever the FSM is not IDLE
//
// Build option: DIV_ARB_ZERO_BYPASS_EN skips the iteration for a zero divisor.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_rs,
    input  logic [NUM_REQ*WIDTH-1:0] req_rt,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_quot,
    output logic [WIDTH-1:0]         resp_rem,
    output logic                     busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [MAX_WIDTH-1:0] DZ_FULL = div_zero_quot(WIDTH);
    localparam logic [MAX_WIDTH-1:0] MN_FULL = most_neg(WIDTH);
    localparam logic [WIDTH-1:0]     DZ_QUOT = DZ_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     MOST_NEG = MN_FULL[WIDTH-1:0];

    state_t state_q, state_d;

    logic [PW-1:0]    rr_ptr_q;
    logic [PW-1:0]    lane_q;
    logic [WIDTH-1:0] rs_abs_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             rt_zero_q;
    logic             ovf_q;

    logic [PW-1:0]    grant_idx;
    logic             found;
    logic             xfer;
    logic [WIDTH-1:0] rs_sel, rt_sel, rs_abs, rt_abs;

    logic             iter_done;
    logic [WIDTH-1:0] iter_quot, iter_rem;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    // Round-robin search starting at rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    // Reset gates the grant so a request coincident with reset is never taken.
    always_comb begin
        req_ready = '0;
        if (reset && state_q == IDLE && found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer   = reset && (state_q == IDLE) && found;
    assign rs_sel = req_rs[int'(grant_idx)*WIDTH +: WIDTH];
    assign rt_sel = req_rt[int'(grant_idx)*WIDTH +: WIDTH];
    assign rs_abs = rs_sel[WIDTH-1] ? -rs_sel : rs_sel;
    assign rt_abs = rt_sel[WIDTH-1] ? -rt_sel : rt_sel;

    div_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .resetn    (reset),
        .start     (xfer),
        .dividend  (rs_abs),
        .divisor   (rt_abs),
        .done      (iter_done),
        .quotient  (iter_quot),
        .remainder (iter_rem)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    state_d = (rt_sel == '0) ? FIX : DIV;
`else
                    state_d = DIV;
`endif
                end
            end
            DIV:     if (iter_done) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sign fix-up. Zero divisor uses the latched |rs| so the bypass path does
    // not depend on the iterator having run.
    always_comb begin
        quot_fix = q_neg_q ? -iter_quot : iter_quot;
        rem_fix  = r_neg_q ? -iter_rem  : iter_rem;
        if (rt_zero_q) begin
            quot_fix = DZ_QUOT;
            rem_fix  = r_neg_q ? -rs_abs_q : rs_abs_q;
        end else if (ovf_q) begin
            quot_fix = MOST_NEG;
            rem_fix  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lane_q    <= '0;
            rs_abs_q  <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rt_zero_q <= 1'b0;
            ovf_q     <= 1'b0;
            resp_quot <= '0;
            resp_rem  <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                lane_q    <= grant_idx;
                rs_abs_q  <= rs_abs;
                q_neg_q   <= rs_sel[WIDTH-1] ^ rt_sel[WIDTH-1];
                r_neg_q   <= rs_sel[WIDTH-1];
                rt_zero_q <= (rt_sel == '0);
                ovf_q     <= (rs_sel == MOST_NEG) && (rt_sel == '1);
                rr_ptr_q  <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
            end
            if (state_q == FIX) begin
                resp_quot <= quot_fix;
                resp_rem  <= rem_fix;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == DONE) begin
            resp_valid[lane_q] = 1'b1;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed self-checking bench for div_arbiter
module tb_div_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int LAT = W + 2;
`ifdef DIV_ARB_ZERO_BYPASS_EN
    localparam int DZ_LAT = 2;
`else
    localparam int DZ_LAT = W + 2;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_rs;
    logic [N*W-1:0] req_rt;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_quot;
    logic [W-1:0]   resp_rem;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    div_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .resp_valid (resp_valid),
        .resp_quot  (resp_quot),
        .resp_rem   (resp_rem),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_lane(input int lane, input logic [W-1:0] rs, input logic [W-1:0] rt);
        req_rs[lane*W +: W] = rs;
        req_rt[lane*W +: W] = rt;
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        req_valid = 4'hF;
        req_rs    = '0;
        req_rt    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (resp_valid !== 4'b0) begin fails++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid); end
        tests++; if (resp_quot !== 32'h0) begin fails++; $display("FAIL reset_quot got=%h exp=0", resp_quot); end
        tests++; if (resp_rem !== 32'h0) begin fails++; $display("FAIL reset_rem got=%h exp=0", resp_rem); end
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        req_valid = 4'h0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic do_op(input string name, input int lane, input logic [W-1:0] rs,
                         input logic [W-1:0] rt, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input int lat);
        logic [N-1:0] exp_oh;
        int t_grant;
        bit got;
        exp_oh = '0;
        exp_oh[lane] = 1'b1;
        @(posedge clk); #1;
        set_lane(lane, rs, rt);
        req_valid = exp_oh;
        got = 1'b0;
        t_grant = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin got = 1'b1; t_grant = cyc; end
        end
        tests++;
        if (!got || req_ready !== exp_oh) begin
            fails++; $display("FAIL %s_grant got=%b exp=%b", name, req_ready, exp_oh);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy got=%b exp=1", name, busy); end
        got = (resp_valid != '0);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (resp_valid != '0) got = 1'b1;
        end
        tests++;
        if (!got || resp_valid !== exp_oh) begin
            fails++; $display("FAIL %s_resp_valid got=%b exp=%b", name, resp_valid, exp_oh);
        end
        tests++;
        if (cyc - t_grant != lat) begin
            fails++; $display("FAIL %s_latency got=%0d exp=%0d", name, cyc - t_grant, lat);
        end
        tests++; if (resp_quot !== eq) begin fails++; $display("FAIL %s_quot got=%h exp=%h", name, resp_quot, eq); end
        tests++; if (resp_rem !== er) begin fails++; $display("FAIL %s_rem got=%h exp=%h", name, resp_rem, er); end
    endtask

    task automatic test_signed_divide;
        do_op("pos_pos",  2, 32'd100,      32'd7,        32'd14,       32'd2,        LAT);
        do_op("neg_pos",  0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, LAT);
        do_op("pos_neg",  3, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        LAT);
        do_op("neg_neg",  1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, LAT);
        do_op("small",    1, 32'd3,        32'd7,        32'd0,        32'd3,        LAT);
        do_op("max_by_1", 2, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        LAT);
        do_op("min_by_2", 0, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        LAT);
    endtask

    task automatic test_div_zero;
        do_op("dz_pos", 1, 32'd5,        32'd0, 32'hFFFFFFFF, 32'd5,        DZ_LAT);
        do_op("dz_neg", 0, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, DZ_LAT);
    endtask

    task automatic test_overflow;
        do_op("ovf", 3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, LAT);
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp_oh;
        int prev;
        bit got;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int l = 0; l < N; l++) set_lane(l, 32'(50 + l), 32'd3);
        req_valid = 4'hF;
        @(posedge clk); #1;
        reset = 1'b1;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            exp_oh = '0;
            exp_oh[g % N] = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk);
                if (req_ready != '0) got = 1'b1;
            end
            tests++;
            if (!got || req_ready !== exp_oh) begin
                fails++; $display("FAIL rr_grant%0d got=%b exp=%b", g, req_ready, exp_oh);
            end
            if (g > 0) begin
                tests++;
                if (cyc - prev != LAT + 1) begin
                    fails++; $display("FAIL rr_spacing%0d got=%0d exp=%0d", g, cyc - prev, LAT + 1);
                end
            end
            prev = cyc;
        end
        req_valid = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_abort;
        bit got;
        bit seen;
        @(posedge clk); #1;
        set_lane(1, 32'd1000, 32'd3);
        req_valid = 4'b0010;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1'b1;
        end
        tests++;
        if (!got || req_ready !== 4'b0010) begin
            fails++; $display("FAIL abort_grant got=%b exp=0010", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        set_lane(3, 32'd9, 32'd2);
        req_valid = 4'b1000;
        @(negedge clk);
        tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL abort_ready_in_reset got=%b exp=0000", req_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL abort_ready_after got=%b exp=1000", req_ready); end
        req_valid = '0;
        seen = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (resp_valid != '0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_resp got=%b exp=0", seen); end
    endtask

    initial begin
        test_reset;
        test_signed_divide;
        test_div_zero;
        test_overflow;
        test_round_robin;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
